// File: rtl/nmi_pkg.sv
// Shared definitions for the NMI request scheduler: source indices, state
// encoding, strobe payload and small helpers.
package nmi_pkg;

  localparam int unsigned NMI_SRCS      = 4;
  localparam int unsigned NMI_SRC_WDOG  = 0;
  localparam int unsigned NMI_SRC_PORT  = 1;
  localparam int unsigned NMI_SRC_MAGIC = 2;
  localparam int unsigned NMI_SRC_BRK   = 3;

  localparam int unsigned CNT_W      = 4;
  localparam int unsigned CNT_MAX    = 15;
  localparam int unsigned ARM_CYCLES = 2;
  localparam int unsigned ARM_W      = 1;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ARM        = 3'd1,
    ST_WAIT_ENTRY = 3'd2,
    ST_ACTIVE     = 3'd3,
    ST_HOLDOFF    = 3'd4
  } nmi_state_e;

  // Strobe lines towards the Z80 NMI generator.
  typedef struct packed {
    logic       imm;
    logic [1:0] set;
  } nmi_strobe_t;

  // Map a one-hot source onto the generator strobe that serves it.
  function automatic nmi_strobe_t strobe_for(input logic [NMI_SRCS-1:0] grant);
    nmi_strobe_t s;
    s        = '0;
    s.imm    = grant[NMI_SRC_BRK];
    s.set[0] = grant[NMI_SRC_MAGIC];
    s.set[1] = grant[NMI_SRC_PORT] | grant[NMI_SRC_WDOG];
    return s;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_W'(CNT_MAX)) ? c : c + CNT_W'(1);
  endfunction

endpackage

// File: rtl/nmi_sched_if.sv
// Request/strobe/status bundle between the NMI sources, the scheduler and
// the NMI generator.
interface nmi_sched_if;
  import nmi_pkg::*;

  logic                req_brk;
  logic                req_magic;
  logic                req_port;
  logic                req_wdog;
  logic                int_start;
  logic                in_nmi;
  logic                cause_rd;
  logic [1:0]          set_nmi;
  logic                imm_nmi;
  logic [NMI_SRCS-1:0] cause;
  logic [NMI_SRCS-1:0] pending;
  logic                busy;
  logic                entry_fail;

  modport master (
    output req_brk, req_magic, req_port, req_wdog, int_start, in_nmi, cause_rd,
    input  set_nmi, imm_nmi, cause, pending, busy, entry_fail
  );

  modport slave (
    input  req_brk, req_magic, req_port, req_wdog, int_start, in_nmi, cause_rd,
    output set_nmi, imm_nmi, cause, pending, busy, entry_fail
  );

endinterface

// File: rtl/nmi_sched_prio_sel.sv
// Combinational fixed-priority selector (brk > magic > port > wdog), one-hot
// out, all-zero when nothing is requested.
module nmi_prio_sel
  import nmi_pkg::*;
(
  input  logic [NMI_SRCS-1:0] req,
  output logic [NMI_SRCS-1:0] grant_c
);

  always_comb begin
    grant_c = '0;
    if (req[NMI_SRC_BRK])        grant_c[NMI_SRC_BRK]   = 1'b1;
    else if (req[NMI_SRC_MAGIC]) grant_c[NMI_SRC_MAGIC] = 1'b1;
    else if (req[NMI_SRC_PORT])  grant_c[NMI_SRC_PORT]  = 1'b1;
    else if (req[NMI_SRC_WDOG])  grant_c[NMI_SRC_WDOG]  = 1'b1;
  end

endmodule

// File: rtl/nmi_sched.sv
// NMI request scheduler: latches source requests, dispatches the highest
// priority one as a generator strobe and tracks NMI entry/exit with hold-off.
module nmi_sched
  import nmi_pkg::*;
#(
  parameter int unsigned ENTRY_TIMEOUT  = 3,
  parameter int unsigned HOLDOFF_FRAMES = 2
) (
  input  logic        fclk,
  input  logic        rst_n,
  nmi_sched_if.slave  bus
);

  nmi_state_e          state_q, state_n;
  logic [NMI_SRCS-1:0] pend_q, pend_n, pend_clr;
  logic [NMI_SRCS-1:0] cause_q, cause_n;
  logic [NMI_SRCS-1:0] req_vec_c, grant_c;
  logic [CNT_W-1:0]    cnt_q, cnt_n;
  logic [ARM_W-1:0]    arm_q, arm_n;
  nmi_strobe_t         stb_q, stb_n;
  logic                fail_q, fail_n;
  logic                busy_q;
  logic                in_nmi_d;
  logic                nmi_rise, nmi_fall;

  assign req_vec_c = {bus.req_brk, bus.req_magic, bus.req_port, bus.req_wdog};
  assign nmi_rise  = bus.in_nmi & ~in_nmi_d;
  assign nmi_fall  = ~bus.in_nmi & in_nmi_d;

  nmi_prio_sel u_prio_sel (
    .req     (pend_q),
    .grant_c (grant_c)
  );

  // State, counters, payload and registered outputs.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pend_q   <= '0;
      cause_q  <= '0;
      cnt_q    <= '0;
      arm_q    <= '0;
      stb_q    <= '0;
      fail_q   <= 1'b0;
      busy_q   <= 1'b0;
      in_nmi_d <= 1'b0;
    end else begin
      state_q  <= state_n;
      pend_q   <= pend_n;
      cause_q  <= cause_n;
      cnt_q    <= cnt_n;
      arm_q    <= arm_n;
      stb_q    <= stb_n;
      fail_q   <= fail_n;
      busy_q   <= (state_n != ST_IDLE);
      in_nmi_d <= bus.in_nmi;
    end
  end

  // Next-state and payload decisions.
  always_comb begin
    state_n  = state_q;
    pend_clr = '0;
    cause_n  = cause_q;
    cnt_n    = cnt_q;
    arm_n    = arm_q;
    stb_n    = '0;
    fail_n   = 1'b0;

    if (bus.cause_rd && (state_q == ST_IDLE || state_q == ST_ACTIVE ||
                         state_q == ST_HOLDOFF)) begin
      cause_n = '0;
    end

    case (state_q)
      ST_IDLE: begin
        if ((pend_q != '0) && !bus.in_nmi) begin
          state_n  = ST_ARM;
          cause_n  = grant_c;
          pend_clr = grant_c;
          arm_n    = '0;
          stb_n    = strobe_for(grant_c);
        end
      end
      ST_ARM: begin
        if (arm_q == ARM_W'(ARM_CYCLES - 1)) begin
          state_n = ST_WAIT_ENTRY;
          cnt_n   = '0;
        end else begin
          arm_n = arm_q + ARM_W'(1);
          stb_n = stb_q;
        end
      end
      ST_WAIT_ENTRY: begin
        // Entry beats a coincident frame tick.
        if (nmi_rise) begin
          state_n = ST_ACTIVE;
        end else if (bus.int_start) begin
          cnt_n = cnt_inc(cnt_q);
          if (cnt_n == CNT_W'(ENTRY_TIMEOUT)) begin
            state_n = ST_IDLE;
            fail_n  = 1'b1;
            cause_n = '0;
          end
        end
      end
      ST_ACTIVE: begin
        if (nmi_fall) begin
          state_n = ST_HOLDOFF;
          cnt_n   = '0;
        end
      end
      ST_HOLDOFF: begin
        if (HOLDOFF_FRAMES == 0) begin
          state_n = ST_IDLE;
        end else if (bus.int_start) begin
          cnt_n = cnt_inc(cnt_q);
          if (cnt_n == CNT_W'(HOLDOFF_FRAMES)) state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // A new request in the dispatch-clear cycle keeps its bit set.
    pend_n = (pend_q & ~pend_clr) | req_vec_c;
  end

  assign bus.set_nmi    = stb_q.set;
  assign bus.imm_nmi    = stb_q.imm;
  assign bus.cause      = cause_q;
  assign bus.pending    = pend_q;
  assign bus.busy       = busy_q;
  assign bus.entry_fail = fail_q;

endmodule

// File: doc/nmi_sched.md
# nmi_sched

NMI request scheduler between the NMI sources (magic key via slave SPI, port #BF write, breakpoint comparator, watchdog) and the Z80 NMI generator. It latches requests, picks one by fixed priority and drives the generator's strobe inputs in the required edge format. It tracks NMI entry and exit through `in_nmi`, and enforces a frame-based hold-off before the next dispatch. It also exposes a one-hot cause register for the NMI handler to read through the ports block.

## Interface
- `ENTRY_TIMEOUT`, default 3: number of `int_start` pulses to wait for `in_nmi` after a strobe before giving up; legal range 1..15.
- `HOLDOFF_FRAMES`, default 2: number of `int_start` pulses after `in_nmi` falls before the next dispatch; legal range 0..15.
- `fclk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low; clock fclk.
- `req_brk`  in  1  breakpoint hit pulse; source index 3.
- `req_magic`  in  1  magic key pulse from slave SPI; source index 2.
- `req_port`  in  1  port #BF NMI-bit write pulse; source index 1.
- `req_wdog`  in  1  watchdog timeout pulse; source index 0.
- `int_start`  in  1  one-fclk pulse at the start of each INT (frame tick).
- `in_nmi`  in  1  level from the NMI generator; 1 while the NMI page is mapped.
- `cause_rd`  in  1  one-fclk pulse on a handler read of the cause port.
- `set_nmi`  out  2  deferred-NMI strobes; the generator acts on the falling edge. Bit 0 is magic; bit 1 is port or wdog.
- `imm_nmi`  out  1  immediate-NMI strobe; the generator acts on the rising edge.
- `cause`  out  4  one-hot cause of the last dispatched NMI.
- `pending`  out  4  latched requests not yet dispatched.
- `busy`  out  1  1 in any state other than IDLE.
- `entry_fail`  out  1  one-cycle pulse when the entry timeout expires.

## Operation
- **Reset values.** All outputs are 0 and the state is IDLE.
- **Request latching.** A request pulse sets its `pending` bit on the next fclk edge. A repeated request from the same source merges into the existing bit.
- **Priority.** brk > magic > port > wdog.
- **States.** IDLE, ARM, WAIT_ENTRY, ACTIVE, HOLDOFF.
- **IDLE.** When `pending` is non-zero and `in_nmi` is 0, the block:
  - selects the highest-priority source;
  - loads `cause` with its one-hot value;
  - clears that `pending` bit;
  - enters ARM.
  If `in_nmi` is 1, dispatch is blocked.
- **ARM.** Lasts exactly 2 cycles. The strobe for the selected source is held high: `imm_nmi` for brk, `set_nmi[0]` for magic, `set_nmi[1]` for port or wdog. The strobe drops on exit, and the block enters WAIT_ENTRY with its frame counter cleared.
- **WAIT_ENTRY.**
  - A rising edge of `in_nmi` moves to ACTIVE.
  - Each `int_start` increments the counter.
  - When the counter reaches `ENTRY_TIMEOUT`, the block pulses `entry_fail`, clears `cause` and returns to IDLE. The request is dropped, not re-pended.
- **ACTIVE.** Requests keep accumulating in `pending`. A falling edge of `in_nmi` moves to HOLDOFF with the counter cleared.
- **HOLDOFF.** Each `int_start` increments the counter. At `HOLDOFF_FRAMES` the block returns to IDLE. With `HOLDOFF_FRAMES`=0 it returns to IDLE on the next cycle.
- **`cause_rd`.** Clears `cause` to 0 in IDLE, ACTIVE and HOLDOFF; it is ignored in ARM and WAIT_ENTRY.
- **Strobe exclusivity.** Only one strobe output is ever high at a time.

## Timing
- **Dispatch latency.** From a request pulse in IDLE:
  - cycle +1: `pending` set;
  - cycle +2: state ARM with the strobe high;
  - cycles +2 and +3: strobe high;
  - cycle +4: strobe low (this is the edge the generator acts on for `set_nmi`).
- **Request on a dispatch-clear cycle.** If a request arrives in the same cycle its `pending` bit is being cleared by dispatch, the set wins and the bit stays 1.
- **Simultaneous `int_start` and `in_nmi` rise in WAIT_ENTRY.** Entry wins: the state goes to ACTIVE and `entry_fail` does not pulse.
- **`in_nmi` already 1 in WAIT_ENTRY.** There is no rising edge, so the block waits for the timeout. The edge detector uses a 1-cycle delayed copy of `in_nmi`, which is reset to 0.
- **Counter width.** 4 bits, saturating at 15, with a compare-equal against the active parameter.
- **Reset mid-operation.** Strobes fall asynchronously and `pending`, `cause` and the counter clear. A half-issued strobe is therefore cut short. This is acceptable because the generator is reset by the same `rst_n`.

## Structure
- **Shared package `nmi_pkg`:**
  - source index constants `NMI_SRC_WDOG`=0, `NMI_SRC_PORT`=1, `NMI_SRC_MAGIC`=2, `NMI_SRC_BRK`=3;
  - state encoding for the five states;
  - `ARM_CYCLES`=2.
- **Sub-module `nmi_prio_sel`.** Combinational 4-to-one-hot priority selector. Output 0 when the input is empty. It is reusable by the ports block's status read.
- **Frame counter.** A single counter shared by WAIT_ENTRY and HOLDOFF; not a separate module.

## Test plan
- **Single magic request.** Pulse `req_magic` in IDLE → `set_nmi[0]` high for cycles +2 and +3 → raise `in_nmi` → ACTIVE, `cause`=4'b0100 → drop `in_nmi` → 2 `int_start` pulses → IDLE, `busy`=0.
- **Priority and merging.** Pulse `req_wdog`, `req_port` and `req_brk` in the same cycle → `imm_nmi` first with `cause`=4'b1000 and `pending`=4'b0011. After the brk NMI completes and hold-off ends, `set_nmi[1]` is issued with `cause`=4'b0010. Then wdog is issued, also on `set_nmi[1]`, with `cause`=4'b0001.
- **Entry timeout.** Strobe issued, `in_nmi` held 0 for 3 `int_start` pulses → `entry_fail` one-cycle pulse, `cause`=0, IDLE, `pending` unchanged.
- **Requests during NMI.** In ACTIVE, pulse `req_port` three times → `pending`=4'b0010, with no strobe until hold-off expires.
- **`cause_rd` gating.** `cause_rd` in ACTIVE clears `cause`. `cause_rd` in ARM leaves `cause` unchanged.
- **Reset mid-ARM.** Assert `rst_n`=0 while a strobe is high → all outputs 0 immediately. After release, the block sits in IDLE and no strobe is issued.
